lsu_bus: RTL and testbench

- Load/store unit directly downstream of the single-cycle core's data port (DataAdr/WriteData/MemWrite, load result).
- Replaces the zero-latency dmem with a word-wide valid/ready memory bus that may insert wait states.
- Performs byte-lane steering for sb/sh/sw, sign/zero extension for lb/lh/lw/lbu/lhu, and misalignment detection.
- Stalls the core, freezing PC and register write, until each access completes.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 80 ++++++++
 rtl/lsu_bus.sv | 184 ++++++++++++++++++
 tb/tb_lsu_bus.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the lsu_bus load/store unit.
//   lsu_state_t      : access FSM states (IDLE, REQ, RESP, DONE)
//   F3_*             : RISC-V load/store funct3 width/sign encodings
//   DEFAULT_TIMEOUT  : default bus-cycle budget per access (used only when
//                      LSU_BUS_TIMEOUT_EN is defined)
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for lsu_bus.
//   Request side (from the core, used when an access is launched):
//     i_we, i_funct3, i_addr_lo -> o_be (byte enables), o_wdata (replicated
//     store data), o_illegal (misaligned address or unsupported funct3).
//   Response side (from latched access info and captured read word):
//     i_ld_funct3, i_ld_off, i_ld_word -> o_ld_data (selected and extended).
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_illegal,
  output logic [31:0] o_ld_data
);

  logic        w_bad_f3;
  logic        w_bad_align;
  logic [31:0] w_shift;

  // Request side: lanes, replication and legality.
  always_comb begin
    o_be        = 4'b0000;
    o_wdata     = 32'h0;
    w_bad_align = 1'b0;
    w_bad_f3    = 1'b0;

    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata     = {2{i_wdata[15:0]}};
        w_bad_align = i_addr_lo[0];
      end
      2'b10: begin
        o_be        = 4'b1111;
        o_wdata     = i_wdata;
        w_bad_align = |i_addr_lo;
      end
      default: w_bad_f3 = 1'b1;
    endcase

    // Stores have no unsigned forms; loads reject only the 110 encoding
    // beyond the width-11 cases caught above.
    if (i_we && i_funct3[2]) begin
      w_bad_f3 = 1'b1;
    end
    if (!i_we && (i_funct3 == 3'b110)) begin
      w_bad_f3 = 1'b1;
    end

    o_illegal = w_bad_f3 | w_bad_align;
  end

  // Response side: move the addressed byte/halfword down to bit 0, then
  // extend. Legal halfword offsets are 0 or 2, so the same shift serves both.
  assign w_shift = i_ld_word >> {i_ld_off, 3'b000};

  always_comb begin
    o_ld_data = 32'h0;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_H:    o_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_W:    o_ld_data = w_shift;
      F3_BU:   o_ld_data = {24'h0, w_shift[7:0]};
      F3_HU:   o_ld_data = {16'h0, w_shift[15:0]};
      default: o_ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_bus.sv
// lsu_bus: load/store unit between a single-cycle core data port and a
// word-wide valid/ready memory bus with wait states.
//
// Optional build macro: LSU_BUS_TIMEOUT_EN enables a per-access timeout of
// TIMEOUT bus cycles that aborts the access and pulses bus_err.
//
// Ports:
//   clk, reset            : clock (rising edge), async active-low reset
//   req, we, funct3       : core access request, store flag, width/sign
//   addr, wdata           : byte address, store data
//   rdata                 : extended load result, non-zero only in DONE
//   stall                 : core holds PC, inputs and register write
//   misalign              : access rejected (misaligned / illegal funct3)
//   bus_valid/bus_ready   : request handshake
//   bus_addr/we/be/wdata  : request payload (word address, lanes, data)
//   bus_rdata/bus_rvalid  : read response
//   bus_err               : timeout abort pulse (0 without the macro)
//   dbg_state             : current FSM state (lsu_state_t encoding)
//
// Handshake: a request transfers on a rising edge where bus_valid and
// bus_ready are both high; while bus_valid is high without bus_ready, the
// payload is held stable. bus_rvalid is sampled only in RESP and must come
// at least one cycle after the request transferred.
module lsu_bus
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rvalid,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic [31:0] r_bus_addr;
  logic        r_bus_we;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_illegal;
  logic [31:0] w_ld_data;
  logic        w_start;
  logic        w_timeout;
  logic        w_abort;

  lsu_align u_align (
    .i_we        (we),
    .i_funct3    (funct3),
    .i_addr_lo   (addr[1:0]),
    .i_wdata     (wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_off),
    .i_ld_word   (r_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_illegal   (w_illegal),
    .o_ld_data   (w_ld_data)
  );

  assign w_start = (r_state == IDLE) && req && !w_illegal;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  // A load accepted on the last REQ cycle enters RESP already at the limit,
  // so RESP compares with >= and the counter never passes TIMEOUT.
  assign w_timeout = (r_cnt >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if (((r_state == REQ) || (r_state == RESP)) && !w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // Next state. A completing handshake is checked before expiry so that a
  // completion in the expiry cycle wins.
  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_next = REQ;
      end
      REQ: begin
        if (bus_ready) begin
          w_next = r_bus_we ? DONE : RESP;
        end else if (w_timeout) begin
          w_next  = DONE;
          w_abort = 1'b1;
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          w_next = DONE;
        end else if (w_timeout) begin
          w_next  = DONE;
          w_abort = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_bus_addr  <= 32'h0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= 32'h0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_rdata     <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      // r_err is high exactly for the DONE cycle that follows an abort.
      r_err   <= w_abort;
      if (w_start) begin
        r_bus_addr  <= {addr[31:2], 2'b00};
        r_bus_we    <= we;
        r_bus_be    <= w_be;
        r_bus_wdata <= w_wdata;
        r_funct3    <= funct3;
        r_off       <= addr[1:0];
      end
      if ((r_state == RESP) && bus_rvalid) begin
        r_rdata <= bus_rdata;
      end
    end
  end

  assign bus_valid = (r_state == REQ);
  assign bus_addr  = r_bus_addr;
  assign bus_we    = r_bus_we;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

  // Only an idle unit evaluates a new access; once launched it is legal.
  assign misalign  = (r_state == IDLE) && req && w_illegal;
  assign stall     = req && !misalign && (r_state != DONE);

  // Aborted loads report 0 rather than a stale captured word.
  assign rdata     = ((r_state == DONE) && !r_bus_we && !r_err) ? w_ld_data : 32'h0;

  assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu_bus.sv
module tb_lsu_bus;
  import lsu_pkg::*;

  localparam int TB_TIMEOUT = 8;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        bus_err;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_fail;

  lsu_bus #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .misalign   (misalign),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .bus_err    (bus_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works in bytes: an access of n bytes must sit on an n-byte boundary,
  // covers bytes off..off+n-1, store lane i carries data byte (i mod n),
  // and a load keeps n bytes starting at off, then extends.
  function automatic void ref_model(
    input  logic        rw,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    output logic        ill,
    output logic [3:0]  be,
    output logic [31:0] swd,
    output logic [31:0] lrd
  );
    int n;
    int off;
    longint unsigned mask;
    longint unsigned v;
    ill = 1'b0;
    be  = 4'h0;
    swd = 32'h0;
    lrd = 32'h0;
    off = int'(a[1:0]);
    if (f3[1:0] == 2'b11) ill = 1'b1;
    else if (rw && f3 > 3'd2) ill = 1'b1;
    else if (!rw && f3 == 3'd6) ill = 1'b1;
    if (ill) return;
    n = 1 << f3[1:0];
    if ((off % n) != 0) begin
      ill = 1'b1;
      return;
    end
    mask = (64'd1 << (8 * n)) - 64'd1;
    be = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) swd[8*i +: 8] = wd[8*(i % n) +: 8];
    v = (64'(rd) >> (8 * off)) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    lrd = v[31:0];
  endfunction

  // ---------------- driver / bus slave ----------------
  // Presents one access and plays the slave: bus_ready after rdy_dly cycles
  // of bus_valid, bus_rvalid after rv_dly RESP cycles. Returns what was seen.
  task automatic run_access(
    input  logic        rw,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    input  int          rdy_dly,
    input  int          rv_dly,
    input  int          max_cyc,
    output int          stalls,
    output logic [31:0] got_rd,
    output logic        got_err,
    output logic        got_mis,
    output logic [31:0] got_addr,
    output logic [3:0]  got_be,
    output logic [31:0] got_wd,
    output logic        got_we,
    output logic        vseen,
    output logic        tmo,
    output logic [1:0]  post_state
  );
    int   vcnt;
    int   rcnt;
    logic accepted;
    logic rv_given;
    logic done;
    stalls = 0; got_rd = '0; got_err = 0; got_mis = 0; got_addr = '0;
    got_be = '0; got_wd = '0; got_we = 0; vseen = 0; tmo = 0;
    vcnt = 0; rcnt = 0; accepted = 0; rv_given = 0; done = 0;
    @(negedge clk);
    req = 1'b1; we = rw; funct3 = f3; addr = a; wdata = wd;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      if (accepted && !rw && !rv_given) begin
        if (rcnt >= rv_dly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rd;
          rv_given   = 1'b1;
        end
        rcnt++;
      end
      if (bus_valid) begin
        vseen = 1'b1;
        if (vcnt >= rdy_dly) bus_ready = 1'b1;
        vcnt++;
      end
      #1;
      got_mis = got_mis | misalign;
      if (bus_valid && bus_ready) begin
        accepted = 1'b1;
        got_addr = bus_addr;
        got_be   = bus_be;
        got_wd   = bus_wdata;
        got_we   = bus_we;
      end
      if (stall) stalls++;
      else begin
        done    = 1'b1;
        got_rd  = rdata;
        got_err = bus_err;
      end
    end
    if (!done) tmo = 1'b1;
    @(posedge clk);
    #1;
    post_state = dbg_state;
    req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic run_and_check(
    input string       tag,
    input logic        rw,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input int          rdy,
    input int          rv,
    input logic        exp_ill,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wd,
    input logic [31:0] exp_rd
  );
    int st; logic [31:0] g_rd; logic g_err; logic g_mis; logic [31:0] g_addr;
    logic [3:0] g_be; logic [31:0] g_wd; logic g_we; logic vs; logic tmo; logic [1:0] ps;
    int exp_st;
    run_access(rw, f3, a, wd, rd, rdy, rv, 60, st, g_rd, g_err, g_mis, g_addr, g_be, g_wd, g_we, vs, tmo, ps);
    exp_st = exp_ill ? 0 : (2 + rdy + (rw ? 0 : rv + 1));
    chk({tag, " misalign"}, 32'(g_mis), 32'(exp_ill));
    chk({tag, " stall_cycles"}, st, exp_st);
    chk({tag, " completed"}, 32'(tmo), 32'd0);
    chk({tag, " bus_err"}, 32'(g_err), 32'd0);
    chk({tag, " end_state"}, 32'(ps), 32'(IDLE));
    if (exp_ill) begin
      chk({tag, " bus_valid_seen"}, 32'(vs), 32'd0);
    end else begin
      chk({tag, " bus_addr"}, g_addr, {a[31:2], 2'b00});
      chk({tag, " bus_be"}, 32'(g_be), 32'(exp_be));
      chk({tag, " bus_we"}, 32'(g_we), 32'(rw));
      if (rw) chk({tag, " bus_wdata"}, g_wd, exp_wd);
    end
    chk({tag, " rdata"}, g_rd, (rw || exp_ill) ? 32'h0 : exp_rd);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string       name;
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          rdy;
    int          rv;
    logic        ill;
    logic [3:0]  be;
    logic [31:0] swd;
    logic [31:0] lrd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int st; logic [31:0] g_rd; logic g_err; logic g_mis; logic [31:0] g_addr;
    logic [3:0] g_be; logic [31:0] g_wd; logic g_we; logic vs; logic tmo; logic [1:0] ps;
    logic m_ill; logic [3:0] m_be; logic [31:0] m_wd; logic [31:0] m_rd;
    logic r_rw; logic [2:0] r_f3; logic [31:0] r_a; logic [31:0] r_wdv; logic [31:0] r_rdv;

    n_cmp = 0; n_fail = 0;
    reset = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0; bus_rvalid = 1'b0;

    vecs[0]  = '{"sw_64",   1'b1, F3_W,   32'h64, 32'h19,       32'h0,        1, 0, 1'b0, 4'b1111, 32'h00000019, 32'h0};
    vecs[1]  = '{"sb_61",   1'b1, F3_B,   32'h61, 32'hABCD12EF, 32'h0,        0, 0, 1'b0, 4'b0010, 32'hEFEFEFEF, 32'h0};
    vecs[2]  = '{"sh_62",   1'b1, F3_H,   32'h62, 32'h1234,     32'h0,        2, 0, 1'b0, 4'b1100, 32'h12341234, 32'h0};
    vecs[3]  = '{"lb_63",   1'b0, F3_B,   32'h63, 32'h0,        32'h80FF7F01, 0, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[4]  = '{"lbu_63",  1'b0, F3_BU,  32'h63, 32'h0,        32'h80FF7F01, 1, 2, 1'b0, 4'b1000, 32'h0,        32'h00000080};
    vecs[5]  = '{"lhu_62",  1'b0, F3_HU,  32'h62, 32'h0,        32'h80FF7F01, 0, 1, 1'b0, 4'b1100, 32'h0,        32'h000080FF};
    vecs[6]  = '{"lw_66",   1'b0, F3_W,   32'h66, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[7]  = '{"lh_61",   1'b0, F3_H,   32'h61, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[8]  = '{"lw_60",   1'b0, F3_W,   32'h60, 32'h0,        32'hDEADBEEF, 0, 0, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF};
    vecs[9]  = '{"lh_60",   1'b0, F3_H,   32'h60, 32'h0,        32'h12348001, 3, 0, 1'b0, 4'b0011, 32'h0,        32'hFFFF8001};
    vecs[10] = '{"ld011",   1'b0, 3'b011, 32'h60, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{"st100",   1'b1, 3'b100, 32'h60, 32'h55,       32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset state", 32'(dbg_state), 32'(IDLE));
    chk("reset bus_valid", 32'(bus_valid), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset bus_addr", bus_addr, 32'h0);
    chk("reset bus_be", 32'(bus_be), 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_and_check(vecs[i].name, vecs[i].rw, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rd,
                    vecs[i].rdy, vecs[i].rv, vecs[i].ill, vecs[i].be, vecs[i].swd, vecs[i].lrd);
    end

    // reset while waiting for read data
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h60;
    @(negedge clk);
    #1 chk("rst_resp in REQ", 32'(bus_valid), 32'd1);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    #1 chk("rst_resp RESP state", 32'(dbg_state), 32'(RESP));
    @(negedge clk);
    #1 chk("rst_resp still stalled", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_resp state", 32'(dbg_state), 32'(IDLE));
    chk("rst_resp bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_resp rdata", rdata, 32'h0);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_and_check("lw_60_after_rst", 1'b0, F3_W, 32'h60, 32'h0, 32'h13579BDF, 0, 3,
                  1'b0, 4'b1111, 32'h0, 32'h13579BDF);

    // reset while the request is on the bus drops bus_valid at once
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = F3_W; addr = 32'h80; wdata = 32'h5A5A5A5A;
    @(negedge clk);
    #1 chk("rst_req valid before", 32'(bus_valid), 32'd1);
    reset = 1'b0;
    #1 chk("rst_req valid after", 32'(bus_valid), 32'd0);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // randomized accesses against the reference model
    for (int i = 0; i < 60; i++) begin
      r_rw  = 1'($urandom_range(0, 1));
      r_f3  = 3'($urandom_range(0, 7));
      r_a   = 32'h100 + 32'($urandom_range(0, 255));
      r_wdv = $urandom;
      r_rdv = $urandom;
      ref_model(r_rw, r_f3, r_a, r_wdv, r_rdv, m_ill, m_be, m_wd, m_rd);
      run_and_check($sformatf("rand%0d", i), r_rw, r_f3, r_a, r_wdv, r_rdv,
                    $urandom_range(0, 3), $urandom_range(0, 2), m_ill, m_be, m_wd, m_rd);
    end

`ifdef LSU_BUS_TIMEOUT_EN
    // slave never ready: abort after TIMEOUT REQ cycles
    run_access(1'b0, F3_W, 32'h70, 32'h0, 32'hFFFFFFFF, 1000, 0, 60,
               st, g_rd, g_err, g_mis, g_addr, g_be, g_wd, g_we, vs, tmo, ps);
    chk("tmo released", 32'(tmo), 32'd0);
    chk("tmo stall_cycles", st, 1 + TB_TIMEOUT);
    chk("tmo bus_err", 32'(g_err), 32'd1);
    chk("tmo rdata", g_rd, 32'h0);
    chk("tmo end_state", 32'(ps), 32'(IDLE));
    @(negedge clk);
    #1 chk("tmo bus_err pulse ends", 32'(bus_err), 32'd0);
    // ready in the expiry cycle completes normally
    run_and_check("ready_at_expiry", 1'b1, F3_W, 32'h74, 32'hCAFEF00D, 32'h0, TB_TIMEOUT - 1, 0,
                  1'b0, 4'b1111, 32'hCAFEF00D, 32'h0);
`else
    // slave never ready: unit waits indefinitely
    run_access(1'b1, F3_W, 32'h70, 32'h1, 32'h0, 1000, 0, 40,
               st, g_rd, g_err, g_mis, g_addr, g_be, g_wd, g_we, vs, tmo, ps);
    chk("hang stall held", 32'(tmo), 32'd1);
    chk("hang bus_err", 32'(bus_err), 32'd0);
    chk("hang state", 32'(ps), 32'(REQ));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
